// File: rtl/tetris_key_pkg.sv
// Shared constants for the Tetris key decoder: HID usages, action bit indices,
// the horizontal auto-shift state encoding and a slot-match helper.
package tetris_key_pkg;

  localparam logic [7:0] HID_A        = 8'h04;
  localparam logic [7:0] HID_D        = 8'h07;
  localparam logic [7:0] HID_W        = 8'h1A;
  localparam logic [7:0] HID_S        = 8'h16;
  localparam logic [7:0] HID_SPACE    = 8'h2C;
  localparam logic [7:0] HID_P        = 8'h13;
  localparam logic [7:0] HID_LEFT     = 8'h50;
  localparam logic [7:0] HID_RIGHT    = 8'h4F;
  localparam logic [7:0] HID_UP       = 8'h52;
  localparam logic [7:0] HID_DOWN     = 8'h51;
  localparam logic [7:0] HID_ROLLOVER = 8'h01;

  localparam int ACT_LEFT   = 0;
  localparam int ACT_RIGHT  = 1;
  localparam int ACT_ROTATE = 2;
  localparam int ACT_SOFT   = 3;
  localparam int ACT_HARD   = 4;
  localparam int ACT_PAUSE  = 5;
  localparam int ACT_W      = 6;

  typedef enum logic [1:0] {
    H_IDLE   = 2'd0,
    H_DELAY  = 2'd1,
    H_REPEAT = 2'd2
  } hstate_e;

  function automatic logic key_in_slots(input logic [31:0] kc, input logic [7:0] usage);
    return (kc[31:24] == usage) | (kc[23:16] == usage) |
           (kc[15:8]  == usage) | (kc[7:0]   == usage);
  endfunction

endpackage

// File: rtl/tetris_key_decoder_if.sv
// Bus between GPIO keycode source / vsync and the key decoder.
// master drives keycode and vsync; slave is the decoder producing actions.
interface tetris_key_decoder_if import tetris_key_pkg::*; ();
  logic [31:0]       keycode;
  logic              vsync;
  logic [ACT_W-1:0]  actions;
  logic              actions_strobe;
  logic              frame_tick;

  modport master (output keycode, vsync,
                  input  actions, actions_strobe, frame_tick);
  modport slave  (input  keycode, vsync,
                  output actions, actions_strobe, frame_tick);
endinterface

// File: rtl/tetris_key_decoder_key_repeat.sv
// Horizontal delayed-auto-shift FSM, advanced once per frame tick.
//   state    | meaning
//   H_IDLE   | no single shift key held
//   H_DELAY  | shift emitted, counting DAS_FRAMES before auto-repeat
//   H_REPEAT | auto-repeating, one shift every ARR_FRAMES
module key_repeat import tetris_key_pkg::*; #(
  parameter int DAS_FRAMES = 10,
  parameter int ARR_FRAMES = 3
) (
  input  logic Clk,
  input  logic Reset,
  input  logic i_tick,
  input  logic i_left,
  input  logic i_right,
  output logic o_left,
  output logic o_right
);

  localparam logic [4:0] DAS_CNT  = 5'(DAS_FRAMES);
  localparam logic [4:0] ARR_LAST = 5'(ARR_FRAMES - 1);

  hstate_e    r_state, w_state_nxt;
  logic [4:0] r_cnt, w_cnt_nxt;
  logic       r_dir, w_dir_nxt;
  logic       w_fire;
  logic       w_one_key;

  assign w_one_key = i_left ^ i_right;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= H_IDLE;
      r_cnt   <= '0;
      r_dir   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_dir   <= w_dir_nxt;
    end
  end

  // r_dir: 1 = right. A direction flip restarts DAS as a fresh press.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_dir_nxt   = r_dir;
    w_fire      = 1'b0;
    if (i_tick) begin
      if (!w_one_key) begin
        w_state_nxt = H_IDLE;
        w_cnt_nxt   = '0;
      end else begin
        case (r_state)
          H_IDLE: begin
            w_fire      = 1'b1;
            w_dir_nxt   = i_right;
            w_cnt_nxt   = 5'd1;
            w_state_nxt = H_DELAY;
          end
          H_DELAY: begin
            if (i_right != r_dir) begin
              w_fire      = 1'b1;
              w_dir_nxt   = i_right;
              w_cnt_nxt   = 5'd1;
            end else if (r_cnt == DAS_CNT) begin
              w_fire      = 1'b1;
              w_cnt_nxt   = '0;
              w_state_nxt = H_REPEAT;
            end else begin
              w_cnt_nxt   = r_cnt + 5'd1;
            end
          end
          H_REPEAT: begin
            if (i_right != r_dir) begin
              w_fire      = 1'b1;
              w_dir_nxt   = i_right;
              w_cnt_nxt   = 5'd1;
              w_state_nxt = H_DELAY;
            end else if (r_cnt == ARR_LAST) begin
              w_fire      = 1'b1;
              w_cnt_nxt   = '0;
            end else begin
              w_cnt_nxt   = r_cnt + 5'd1;
            end
          end
          default: begin
            w_state_nxt = H_IDLE;
            w_cnt_nxt   = '0;
          end
        endcase
      end
    end
  end

  always_comb begin
    o_left  = w_fire & ~w_dir_nxt;
    o_right = w_fire &  w_dir_nxt;
  end

endmodule

// File: rtl/tetris_key_decoder.sv
// Turns polled HID keycodes into per-frame Tetris actions, aligned to vsync.
// Optional build macro KEYMAP_ARROWS_EN adds arrow-key aliases.
module tetris_key_decoder import tetris_key_pkg::*; #(
  parameter int DAS_FRAMES = 10,
  parameter int ARR_FRAMES = 3
) (
  input  logic                 Clk,
  input  logic                 Reset,
  tetris_key_decoder_if.slave  bus
);

  logic             r_vs_s1, r_vs_s2, r_vs_s3;
  logic             r_frame_tick;
  logic [ACT_W-1:0] r_prev_held;
  logic             r_first;
  logic [ACT_W-1:0] r_actions;
  logic             r_strobe;

  logic [ACT_W-1:0] w_held_raw, w_held, w_actions_nxt;
  logic             w_rollover;
  logic             w_shift_l, w_shift_r;
  logic             w_vs_fall;

  assign w_vs_fall = r_vs_s3 & ~r_vs_s2;

  always_comb begin
    w_held_raw             = '0;
    w_held_raw[ACT_LEFT]   = key_in_slots(bus.keycode, HID_A);
    w_held_raw[ACT_RIGHT]  = key_in_slots(bus.keycode, HID_D);
    w_held_raw[ACT_ROTATE] = key_in_slots(bus.keycode, HID_W);
    w_held_raw[ACT_SOFT]   = key_in_slots(bus.keycode, HID_S);
    w_held_raw[ACT_HARD]   = key_in_slots(bus.keycode, HID_SPACE);
    w_held_raw[ACT_PAUSE]  = key_in_slots(bus.keycode, HID_P);
`ifdef KEYMAP_ARROWS_EN
    w_held_raw[ACT_LEFT]   = w_held_raw[ACT_LEFT]   | key_in_slots(bus.keycode, HID_LEFT);
    w_held_raw[ACT_RIGHT]  = w_held_raw[ACT_RIGHT]  | key_in_slots(bus.keycode, HID_RIGHT);
    w_held_raw[ACT_ROTATE] = w_held_raw[ACT_ROTATE] | key_in_slots(bus.keycode, HID_UP);
    w_held_raw[ACT_SOFT]   = w_held_raw[ACT_SOFT]   | key_in_slots(bus.keycode, HID_DOWN);
`endif
  end

  // A rollover report carries no key state, so the last good frame stands in for it.
  assign w_rollover = (bus.keycode == {4{HID_ROLLOVER}});
  assign w_held     = w_rollover ? r_prev_held : w_held_raw;

  key_repeat #(
    .DAS_FRAMES (DAS_FRAMES),
    .ARR_FRAMES (ARR_FRAMES)
  ) u_key_repeat (
    .Clk     (Clk),
    .Reset   (Reset),
    .i_tick  (r_frame_tick),
    .i_left  (w_held[ACT_LEFT]),
    .i_right (w_held[ACT_RIGHT]),
    .o_left  (w_shift_l),
    .o_right (w_shift_r)
  );

  always_comb begin
    w_actions_nxt             = '0;
    w_actions_nxt[ACT_LEFT]   = w_shift_l;
    w_actions_nxt[ACT_RIGHT]  = w_shift_r;
    w_actions_nxt[ACT_ROTATE] = w_held[ACT_ROTATE] & ~r_prev_held[ACT_ROTATE] & ~r_first;
    w_actions_nxt[ACT_SOFT]   = w_held[ACT_SOFT];
    w_actions_nxt[ACT_HARD]   = w_held[ACT_HARD]   & ~r_prev_held[ACT_HARD]   & ~r_first;
    w_actions_nxt[ACT_PAUSE]  = w_held[ACT_PAUSE]  & ~r_prev_held[ACT_PAUSE]  & ~r_first;
  end

  // r_first masks press edges on the first tick after reset, when r_prev_held is stale.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_vs_s1      <= 1'b1;
      r_vs_s2      <= 1'b1;
      r_vs_s3      <= 1'b1;
      r_frame_tick <= 1'b0;
      r_prev_held  <= '0;
      r_first      <= 1'b1;
      r_actions    <= '0;
      r_strobe     <= 1'b0;
    end else begin
      r_vs_s1      <= bus.vsync;
      r_vs_s2      <= r_vs_s1;
      r_vs_s3      <= r_vs_s2;
      r_frame_tick <= w_vs_fall;
      r_strobe     <= r_frame_tick;
      if (r_frame_tick) begin
        r_actions   <= w_actions_nxt;
        r_prev_held <= w_held;
        r_first     <= 1'b0;
      end
    end
  end

  assign bus.actions        = r_actions;
  assign bus.actions_strobe = r_strobe;
  assign bus.frame_tick     = r_frame_tick;

endmodule

// File: tb/tb_tetris_key_decoder.sv
// Scoreboard bench for tetris_key_decoder: each frame queues its expected
// action vector, a monitor pops and compares on every actions_strobe.
module tb_tetris_key_decoder;

  localparam logic [5:0] E_L   = 6'b000001;
  localparam logic [5:0] E_R   = 6'b000010;
  localparam logic [5:0] E_ROT = 6'b000100;
  localparam logic [5:0] E_SD  = 6'b001000;
  localparam logic [5:0] E_HD  = 6'b010000;
  localparam logic [5:0] E_NONE = 6'b000000;

  logic Clk = 1'b0;
  logic Reset;

  tetris_key_decoder_if bus();

  tetris_key_decoder #(
    .DAS_FRAMES (10),
    .ARR_FRAMES (3)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  logic [5:0] exp_q[$];
  string      name_q[$];
  int         n_tests = 0;
  int         n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic do_frame(input logic [31:0] kc, input logic [5:0] exp, input string name);
    int  n;
    logic got;
    bus.keycode = kc;
    exp_q.push_back(exp);
    name_q.push_back(name);
    bus.vsync = 1'b0;
    n   = 0;
    got = 1'b0;
    while (!got && n < 8) begin
      @(negedge Clk);
      n++;
      got = bus.frame_tick;
    end
    check({name, " tick_latency"}, n, 32'd3);
    repeat (3) @(negedge Clk);
    bus.vsync = 1'b1;
    repeat (12) @(negedge Clk);
  endtask

  initial begin
    logic [5:0] e;
    string nm;
    Reset       = 1'b1;
    bus.vsync   = 1'b1;
    bus.keycode = 32'h0;

    fork
      forever begin
        @(negedge Clk);
        if (bus.actions_strobe) begin
          if (exp_q.size() == 0) begin
            check("unexpected_strobe", 32'd1, 32'd0);
          end else begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            check(nm, {26'd0, bus.actions}, {26'd0, e});
          end
        end
      end
      begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "timeout");
      end
    join_none

    repeat (3) @(negedge Clk);
    check("reset_state", {29'd0, bus.actions == 6'd0, bus.actions_strobe, bus.frame_tick}, 32'h4);
    Reset = 1'b0;
    repeat (2) @(negedge Clk);

    // D held 20 frames: DAS 10, ARR 3
    for (int f = 1; f <= 20; f++)
      do_frame(32'h0000_0007, (f inside {1, 11, 14, 17, 20}) ? E_R : E_NONE,
               $sformatf("das_right_f%0d", f));
    do_frame(32'h0, E_NONE, "release_a");

    for (int f = 1; f <= 5; f++)
      do_frame(32'h0004_0007, E_NONE, $sformatf("left_and_right_f%0d", f));
    do_frame(32'h0, E_NONE, "release_b");

    for (int f = 1; f <= 8; f++)
      do_frame((f == 6) ? 32'h0 : 32'h0000_001A, (f == 1 || f == 7) ? E_ROT : E_NONE,
               $sformatf("rotate_edge_f%0d", f));
    do_frame(32'h0, E_NONE, "release_c");

    // Space+S with a rollover report in frame 3
    for (int f = 1; f <= 5; f++)
      do_frame((f == 3) ? 32'h0101_0101 : 32'h0000_2C16, (f == 1) ? (E_HD | E_SD) : E_SD,
               $sformatf("rollover_f%0d", f));
    do_frame(32'h0, E_NONE, "release_d");

    // A in slot 3 then D in slot 2: direction change is a fresh press
    for (int f = 1; f <= 14; f++)
      do_frame((f <= 3) ? 32'h0400_0000 : 32'h0007_0000,
               (f == 1) ? E_L : ((f == 4 || f == 14) ? E_R : E_NONE),
               $sformatf("dir_change_f%0d", f));
    do_frame(32'h0, E_NONE, "release_e");

    do_frame(32'h0000_041A, E_L | E_ROT, "pre_reset");
    Reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      check($sformatf("in_reset_%0d", i),
            {24'd0, bus.actions, bus.actions_strobe, bus.frame_tick}, 32'd0);
    end
    Reset = 1'b0;
    repeat (2) @(negedge Clk);
    do_frame(32'h0004_1A13, E_L,    "post_reset_f1");
    do_frame(32'h0004_1A13, E_NONE, "post_reset_f2");
    do_frame(32'h0000_0004, E_NONE, "post_reset_f3");
    do_frame(32'h0000_041A, E_ROT,  "post_reset_f4");
    do_frame(32'h0, E_NONE, "release_f");

`ifdef KEYMAP_ARROWS_EN
    do_frame(32'h0000_0050, E_L,    "arrow_left_f1");
    do_frame(32'h0000_0050, E_NONE, "arrow_left_f2");
`else
    do_frame(32'h0000_0050, E_NONE, "arrow_left_f1");
    do_frame(32'h0000_0050, E_NONE, "arrow_left_f2");
`endif
    do_frame(32'h0, E_NONE, "release_g");

    repeat (5) @(negedge Clk);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tetris_key_decoder.md
# tetris_key_decoder

Reads the raw USB HID keycode word that the MicroBlaze GPIO writes each poll and turns it into per-frame game actions (shift left/right, rotate, soft drop, hard drop, pause). It sits between the `keycode0_gpio` bus and the game-logic block. It is clocked on the 100 MHz system clock and frame-aligned by synchronizing `vsync`. Horizontal shifts use delayed auto-shift (DAS) with an auto-repeat rate (ARR); the other actions fire on key press only.

## Interface
- `DAS_FRAMES`, default 10: frames a shift key must be held before auto-repeat starts (1..31).
- `ARR_FRAMES`, default 3: frames between auto-repeat shifts (1..31).
- Clock and reset: one clock; reset is asynchronous and active-high.
- `Clk`  in  1: 100 MHz system clock, the same clock as the GPIO.
- `Reset`  in  1: asynchronous, active-high reset.
- `keycode`  in  32: four 8-bit HID usage slots, [31:24]..[7:0], synchronous to `Clk`.
- `vsync`  in  1: active-low VGA vsync from the 25 MHz pixel domain.
- `actions`  out  6: {pause, hard_drop, soft_drop, rotate, right, left}, held stable for one frame.
- `actions_strobe`  out  1: one-cycle pulse when `actions` updates.
- `frame_tick`  out  1: one-cycle pulse at each frame start, for debug and test.

## Operation
- Frame tick:
  - Two-flop synchronizer on `vsync`, with reset value 1.
  - A falling-edge detect produces `frame_tick`.
- Key-held vector:
  - On `frame_tick`, a key counts as held if any of the 4 slots equals its usage.
  - Keymap: A=0x04 left, D=0x07 right, W=0x1A rotate, S=0x16 soft drop, Space=0x2C hard drop, P=0x13 pause.
  - 0x00 slots are ignored.
- Rollover error: if all four slots are 0x01, the frame is treated as if the held vector were unchanged.
  - No new presses are detected.
  - The repeat FSM still advances.
- Edge actions (rotate, hard_drop, pause): asserted for the frame in which held goes 0->1 versus the previous tick.
- soft_drop: asserted in every frame its key is held.
- Horizontal FSM with states IDLE, DELAY, REPEAT, a direction bit, and a 5-bit frame counter:
  - IDLE: exactly one of left/right held -> emit that shift, counter=1, go to DELAY.
  - DELAY: same key still held -> counter++. When counter reaches DAS_FRAMES -> emit shift, counter=0, go to REPEAT.
  - REPEAT: same key still held -> counter++. When counter reaches ARR_FRAMES -> emit shift, counter=0.
  - From any state, with both left and right held, or neither -> go to IDLE, no shift.
  - A direction change while in DELAY or REPEAT -> treated as a fresh press: emit the new direction, counter=1, go to DELAY.
- Outputs change only on the cycle after `frame_tick`. Between ticks, `actions` holds its value.

## Timing
- Reset values: `actions`=0, `actions_strobe`=0, `frame_tick`=0, FSM=IDLE, counter=0, previous-held=0, sync flops=1.
- `vsync` falling edge to `frame_tick`: 3 `Clk` cycles (2 synchronizer stages plus 1 edge register).
- `keycode` is sampled on the `frame_tick` cycle. `actions` and `actions_strobe` are registered 1 cycle later.
- Reset asserted mid-frame clears all state immediately. The first tick after release cannot count as a press edge for keys that were already held when reset was asserted.
  - Previous-held is loaded from the first tick after reset with no edge output.
- Keycode changes between ticks are invisible: presses shorter than one frame may be missed. This is the required behaviour.

## Configuration
- `KEYMAP_ARROWS_EN`:
  - Defined: adds arrow-key aliases, OR-ed into the held vector. Left 0x50 -> left, Right 0x4F -> right, Up 0x52 -> rotate, Down 0x51 -> soft drop.
  - Undefined: WASD/Space/P only, and the arrow usages are ignored.

## Structure
- `tetris_key_pkg`:
  - HID usage localparams.
  - Action index constants: ACT_LEFT=0 .. ACT_PAUSE=5.
  - Horizontal FSM state enum.
- One sub-module, `key_repeat`: the IDLE/DELAY/REPEAT FSM with the DAS/ARR parameters. It is advanced by `frame_tick` and emits a one-frame shift flag.

## Test plan
- D (0x07) in slot 0, held 20 frames, defaults 10/3 -> right asserted in frames 1, 11, 14, 17, 20 and deasserted in all other frames.
- `keycode`=0x0004_0007 (left and right together) for 5 frames -> left=right=0 in every frame, FSM stays IDLE.
- W held 5 frames, released 1 frame, then held again -> rotate=1 only in frames 1 and 7.
- `keycode`=0x0101_0101 injected in frame 3 while Space is held from frame 1 -> hard_drop is asserted only in frame 1.
- Reset pulsed mid-frame while A is held, then released -> all outputs 0 during reset; after release, left resumes as a fresh press with no rotate/pause glitch.
- Arrow key 0x50 held -> left pulses when built with `KEYMAP_ARROWS_EN`; `actions`=0 when built without it.
